// File: rtl/guess_entry.sv
// Debounces digit/confirm buttons, assembles a 4-digit unique BCD code, strobes confirm with the guess.
// Latency: raw press to entry update DEBOUNCE_CYCLES+3 edges. There is no backpressure: events are consumed on the cycle they occur.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_in,
  input  logic        key_digit,
  input  logic        key_confirm,
  output logic [15:0] guess,
  output logic        confirm,
  output logic [15:0] entry,
  output logic [2:0]  digit_count,
  output logic        error
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Index 0 is the digit button and index 1 is the confirm button.
  logic [1:0]    raw;
  logic [1:0]    sync_meta;
  logic [1:0]    sync;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [CW-1:0] deb_cnt [2];
  logic [1:0]    press;
  logic          digit_ev;
  logic          confirm_ev;
  logic          dup;
  logic          reject;

  assign raw = {key_confirm, key_digit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
      deb       <= '0;
      deb_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      deb_q     <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] != deb[i]) begin
          if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // A confirm that coincides with a digit event is dropped.
  assign press      = deb & ~deb_q;
  assign digit_ev   = press[0];
  assign confirm_ev = press[1] & ~press[0];

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < digit_count) && (entry[i*4 +: 4] == digit_in)) begin
        dup = 1'b1;
      end
    end
  end

  assign reject = (digit_in > 4'd9) || dup || (digit_count == 3'd4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      guess       <= '0;
      confirm     <= 1'b0;
      entry       <= '0;
      digit_count <= '0;
      error       <= 1'b0;
    end else begin
      confirm <= 1'b0;
      if (digit_ev) begin
        if (reject) begin
          error <= 1'b1;
        end else begin
          entry       <= {entry[11:0], digit_in};
          digit_count <= digit_count + 3'd1;
          error       <= 1'b0;
        end
      end else if (confirm_ev) begin
        case (digit_count)
          3'd4: begin
            guess       <= entry;
            confirm     <= 1'b1;
            entry       <= '0;
            digit_count <= '0;
            error       <= 1'b0;
          end
          // An empty entry acknowledges the result screens downstream.
          3'd0: begin
            confirm <= 1'b1;
            error   <= 1'b0;
          end
          default: error <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Randomized and directed stimulus against a queue-of-digits model; a negedge monitor drains the expectation queues.
module tb_guess_entry;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit_in = '0;
  logic        key_digit = 1'b0;
  logic        key_confirm = 1'b0;
  logic [15:0] guess;
  logic        confirm;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        error;

  guess_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .digit_in(digit_in), .key_digit(key_digit),
    .key_confirm(key_confirm), .guess(guess), .confirm(confirm), .entry(entry),
    .digit_count(digit_count), .error(error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        err;
    logic [15:0] guess;
    logic        conf;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] guess_q[$];

  // Reference model: the accepted digits as a plain list.
  int          m_q[$];
  logic        m_err = 1'b0;
  logic [15:0] m_guess = '0;

  function automatic logic [15:0] m_entry();
    int v = 0;
    foreach (m_q[i]) v = (v * 16) + m_q[i];
    return 16'(v);
  endfunction

  function automatic void m_digit(input int v);
    bit dup = 0;
    foreach (m_q[i]) if (m_q[i] == v) dup = 1;
    if (v > 9 || dup || m_q.size() == 4) m_err = 1'b1;
    else begin
      m_q.push_back(v);
      m_err = 1'b0;
    end
  endfunction

  task automatic issue(input bit kd, input bit kc, input int v);
    rec_t r;
    bit p = 0;
    if (kd) m_digit(v);
    else if (kc) begin
      if (m_q.size() == 4) begin
        m_guess = m_entry();
        m_q.delete();
        m_err = 1'b0;
        p = 1;
      end else if (m_q.size() == 0) begin
        m_err = 1'b0;
        p = 1;
      end else m_err = 1'b1;
    end
    r.due = cyc + D + 3;
    r.entry = m_entry();
    r.cnt = 3'(m_q.size());
    r.err = m_err;
    r.guess = m_guess;
    r.conf = p;
    exp_q.push_back(r);
    if (p) guess_q.push_back(m_guess);
  endtask

  // Called at a negedge; the next posedge is the first to sample the press.
  task automatic press(input bit kd, input bit kc, input int v, input int hold);
    digit_in = 4'(v);
    key_digit = kd;
    key_confirm = kc;
    issue(kd, kc, v);
    repeat (hold) @(negedge clock);
    key_digit = 1'b0;
    key_confirm = 1'b0;
    repeat (D + 5) @(negedge clock);
  endtask

  task automatic glitch(input bit sel, input int n);
    for (int k = 0; k < n; k++) begin
      if (sel) key_confirm = 1'b1; else key_digit = 1'b1;
      repeat (3) @(negedge clock);
      key_digit = 1'b0;
      key_confirm = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  // Monitor: holds the currently expected outputs and applies records on their due cycle.
  logic [15:0] cur_entry = '0;
  logic [2:0]  cur_cnt = '0;
  logic        cur_err = 1'b0;
  logic [15:0] cur_guess = '0;

  always @(negedge clock) begin
    logic exp_conf;
    rec_t r;
    if (reset) begin
      cur_entry = '0;
      cur_cnt = '0;
      cur_err = 1'b0;
      cur_guess = '0;
    end else begin
      exp_conf = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        r = exp_q.pop_front();
        chk("stale_event_due", 32'(r.due), 32'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        cur_entry = r.entry;
        cur_cnt = r.cnt;
        cur_err = r.err;
        cur_guess = r.guess;
        exp_conf = r.conf;
      end
      chk("entry", 32'(entry), 32'(cur_entry));
      chk("digit_count", 32'(digit_count), 32'(cur_cnt));
      chk("error", 32'(error), 32'(cur_err));
      chk("guess_hold", 32'(guess), 32'(cur_guess));
      chk("confirm", 32'(confirm), 32'(exp_conf));
      if (confirm === 1'b1) begin
        if (guess_q.size() == 0) chk("unexpected_confirm", 32'(1), 32'(0));
        else chk("confirm_guess", 32'(guess), 32'(guess_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clock);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, v, h;
    repeat (3) @(negedge clock);
    chk("rst_guess", 32'(guess), 32'h0);
    chk("rst_entry", 32'(entry), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_confirm", 32'(confirm), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    press(1, 0, 1, D + 4);
    press(1, 0, 2, D + 4);
    press(1, 0, 3, D + 4);
    press(1, 0, 4, D + 4);
    chk("t1_entry", 32'(entry), 32'h1234);
    chk("t1_count", 32'(digit_count), 32'd4);
    press(0, 1, 0, D + 4);
    chk("t1_guess", 32'(guess), 32'h1234);
    chk("t1_entry_clr", 32'(entry), 32'h0);

    press(0, 1, 0, D + 6);
    chk("t5_ack_guess", 32'(guess), 32'h1234);

    press(1, 0, 10, D + 4);
    chk("t3_err", 32'(error), 32'd1);
    chk("t3_count", 32'(digit_count), 32'd0);
    press(1, 0, 7, D + 4);
    press(0, 1, 0, D + 4);
    chk("t3_err2", 32'(error), 32'd1);
    chk("t3_count2", 32'(digit_count), 32'd1);
    press(1, 0, 8, D + 4);
    press(1, 0, 9, D + 4);
    press(1, 0, 0, D + 4);
    press(0, 1, 0, D + 4);
    chk("t3_guess", 32'(guess), 32'h7890);

    press(1, 0, 5, D + 4);
    press(1, 0, 5, D + 4);
    chk("t2_entry", 32'(entry), 32'h0005);
    chk("t2_err", 32'(error), 32'd1);
    press(1, 0, 6, D + 4);
    chk("t2_entry2", 32'(entry), 32'h0056);
    chk("t2_err2", 32'(error), 32'd0);
    press(1, 0, 1, D + 4);
    press(1, 0, 2, D + 4);
    press(0, 1, 0, D + 4);

    press(1, 1, 4, D + 4);
    chk("t5_collide_count", 32'(digit_count), 32'd1);

    glitch(0, 4);
    press(1, 0, 0, D + 12);
    chk("t4_entry", 32'(entry), 32'h0040);

    press(1, 0, 8, D + 4);
    press(1, 0, 9, D + 4);
    chk("t6_pre_entry", 32'(entry), 32'h4089);
    #2 reset = 1'b1;
    #1;
    chk("t6_guess", 32'(guess), 32'h0);
    chk("t6_entry", 32'(entry), 32'h0);
    chk("t6_count", 32'(digit_count), 32'h0);
    chk("t6_error", 32'(error), 32'h0);
    exp_q.delete();
    guess_q.delete();
    m_q.delete();
    m_err = 1'b0;
    m_guess = '0;
    digit_in = 4'd3;
    key_digit = 1'b1;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    issue(1, 0, 3);
    repeat (D + 10) @(negedge clock);
    key_digit = 1'b0;
    repeat (D + 5) @(negedge clock);
    chk("t6_post_count", 32'(digit_count), 32'd1);

    for (int n = 0; n < 70; n++) begin
      op = $urandom_range(0, 9);
      v = $urandom_range(0, 11);
      h = D + 2 + $urandom_range(0, 8);
      if (op <= 5) press(1, 0, v, h);
      else if (op <= 7) press(0, 1, 0, h);
      else if (op == 8) press(1, 1, v, h);
      else begin
        glitch(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        repeat (D + 5) @(negedge clock);
      end
    end

    repeat (4) @(negedge clock);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("guess_q_drained", 32'(guess_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
